// File: rtl/arbitro_memoria_objetos.sv
// Round-robin arbiter for the shared asteroid/shot object memory in jogo_base.
// One requester at a time gets the memory through req/grant/done, with a hold timeout.
module arbitro_memoria_objetos #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         done,
  input  logic                     habilitado,
  input  logic                     prioridade,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     ocupado,
  output logic                     timeout_err,
  output logic [3:0]               db_estado
);

  localparam int IDW = $clog2(N_REQ);
  localparam int TW  = $clog2(TIMEOUT);
  localparam logic [TW-1:0]  TIMER_MAX = TW'(TIMEOUT - 1);
  localparam logic [IDW-1:0] PTR_RST   = IDW'(N_REQ - 1);

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    ARBITRA   = 4'd1,
    CONCEDIDO = 4'd2,
    LIBERA    = 4'd3
  } estado_t;

  estado_t          state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic             ocupado_q, ocupado_d;
  logic             timeout_err_q, timeout_err_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic             win_found;
  logic [IDW-1:0]   win_id;
  logic [IDW-1:0]   cand;
  logic [N_REQ-1:0] win_onehot;
  logic             release_req;

  // Winner search: requester 0 under priority override, else first set bit after ptr.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    if (prioridade && req[0]) begin
      win_found = 1'b1;
      win_id    = '0;
    end else begin
      for (int off = 1; off <= N_REQ; off++) begin
        cand = IDW'((int'(ptr_q) + off) % N_REQ);
        if (!win_found && req[cand]) begin
          win_found = 1'b1;
          win_id    = cand;
        end
      end
    end
  end

  always_comb begin
    win_onehot         = '0;
    win_onehot[win_id] = 1'b1;
  end

  // Only the current holder's own done or dropped request counts as a release.
  assign release_req = done[grant_id_q] || !req[grant_id_q];

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    ocupado_d     = ocupado_q;
    timeout_err_d = 1'b0;
    timer_d       = timer_q;
    ptr_d         = ptr_q;
    unique case (state_q)
      OCIOSO: begin
        if (habilitado && (|req)) state_d = ARBITRA;
      end
      ARBITRA: begin
        if (!win_found) begin
          state_d = OCIOSO;
        end else begin
          state_d    = CONCEDIDO;
          grant_d    = win_onehot;
          grant_id_d = win_id;
          ocupado_d  = 1'b1;
          timer_d    = '0;
        end
      end
      CONCEDIDO: begin
        if (release_req) begin
          state_d   = LIBERA;
          grant_d   = '0;
          ocupado_d = 1'b0;
        end else if (timer_q == TIMER_MAX) begin
          state_d       = LIBERA;
          grant_d       = '0;
          ocupado_d     = 1'b0;
          timeout_err_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      LIBERA: begin
        // The requester just served drops to lowest round-robin priority.
        ptr_d   = grant_id_q;
        state_d = OCIOSO;
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= OCIOSO;
      grant_q       <= '0;
      grant_id_q    <= '0;
      ocupado_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      timer_q       <= '0;
      ptr_q         <= PTR_RST;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      ocupado_q     <= ocupado_d;
      timeout_err_q <= timeout_err_d;
      timer_q       <= timer_d;
      ptr_q         <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign ocupado     = ocupado_q;
  assign timeout_err = timeout_err_q;
  assign db_estado   = state_q;

endmodule

// File: tb/tb_arbitro_memoria_objetos.sv
// Directed bench for arbitro_memoria_objetos: a per-cycle vector table plus
// hand-written sequences for round-robin order, priority, timeout, enable and reset.
module tb_arbitro_memoria_objetos;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] done;
  logic       habilitado;
  logic       prioridade;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       ocupado;
  logic       timeout_err;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;

  arbitro_memoria_objetos #(.N_REQ(4), .TIMEOUT(64)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .done       (done),
    .habilitado (habilitado),
    .prioridade (prioridade),
    .grant      (grant),
    .grant_id   (grant_id),
    .ocupado    (ocupado),
    .timeout_err(timeout_err),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] done;
    logic [3:0] g;
    logic [1:0] id;
    logic       oc;
    logic       te;
    logic [3:0] st;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    check("onehot", 32'($countones(grant) <= 1), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_grant(input string nm, input logic [3:0] exp);
    int n;
    n = 0;
    while (grant == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    check(nm, 32'(grant), 32'(exp));
  endtask

  task automatic pulse_done(input logic [3:0] d);
    done = d;
    tick();
    done = 4'b0;
  endtask

  initial begin
    int held;
    logic [1:0] order [5];
    reset      = 1'b0;
    req        = 4'b0;
    done       = 4'b0;
    habilitado = 1'b1;
    prioridade = 1'b0;

    // rst_n, req, done -> grant, grant_id, ocupado, timeout_err, db_estado
    tbl[0]  = '{1'b0, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{1'b1, 4'h1, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 4'd1};
    tbl[2]  = '{1'b1, 4'h1, 4'h0, 4'h1, 2'd0, 1'b1, 1'b0, 4'd2};
    tbl[3]  = '{1'b1, 4'h1, 4'h0, 4'h1, 2'd0, 1'b1, 1'b0, 4'd2};
    tbl[4]  = '{1'b1, 4'h1, 4'h0, 4'h1, 2'd0, 1'b1, 1'b0, 4'd2};
    tbl[5]  = '{1'b1, 4'h1, 4'h0, 4'h1, 2'd0, 1'b1, 1'b0, 4'd2};
    tbl[6]  = '{1'b1, 4'h1, 4'h0, 4'h1, 2'd0, 1'b1, 1'b0, 4'd2};
    tbl[7]  = '{1'b1, 4'h1, 4'h1, 4'h0, 2'd0, 1'b0, 1'b0, 4'd3};
    tbl[8]  = '{1'b1, 4'h1, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 4'd0};
    tbl[9]  = '{1'b1, 4'h1, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 4'd1};
    tbl[10] = '{1'b1, 4'h1, 4'h0, 4'h1, 2'd0, 1'b1, 1'b0, 4'd2};
    tbl[11] = '{1'b1, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 4'd3};
    tbl[12] = '{1'b1, 4'h0, 4'h0, 4'h0, 2'd0, 1'b0, 1'b0, 4'd0};

    for (int i = 0; i < 13; i++) begin
      reset = tbl[i].rst_n;
      req   = tbl[i].req;
      done  = tbl[i].done;
      tick();
      check($sformatf("vec%0d", i),
            32'({grant, grant_id, ocupado, timeout_err, db_estado}),
            32'({tbl[i].g, tbl[i].id, tbl[i].oc, tbl[i].te, tbl[i].st}));
    end
    done = 4'b0;

    // Round-robin order with all four requesting
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'b0000;
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant($sformatf("rr_grant%0d", k), 4'b0001 << order[k]);
      check($sformatf("rr_id%0d", k), 32'(grant_id), 32'(order[k]));
      repeat (3) tick();
      pulse_done(4'b0001 << order[k]);
      check($sformatf("rr_rel%0d", k), 32'({grant, ocupado, db_estado}), 32'({4'b0, 1'b0, 4'd3}));
    end

    // Priority override: requester 0 raised mid-grant wins next
    req = 4'b0000;
    do_reset();
    prioridade = 1'b1;
    req = 4'b1110;
    wait_grant("pri_first", 4'b0010);
    req = 4'b1111;
    repeat (2) tick();
    pulse_done(4'b0010);
    wait_grant("pri_second", 4'b0001);
    pulse_done(4'b0001);
    prioridade = 1'b0;
    req = 4'b0000;
    tick();

    // Hold timeout, then round-robin resumes after the timed-out requester
    do_reset();
    req = 4'b0100;
    wait_grant("to_grant", 4'b0100);
    held = 1;
    while (grant != 4'b0 && held < 200) begin
      tick();
      if (grant != 4'b0) held++;
    end
    check("to_held_cycles", 32'(held), 32'd64);
    check("to_err_pulse", 32'({timeout_err, db_estado}), 32'({1'b1, 4'd3}));
    tick();
    check("to_err_single", 32'({timeout_err, db_estado}), 32'({1'b0, 4'd0}));
    req = 4'b1100;
    wait_grant("to_rr_next", 4'b1000);
    req = 4'b0000;
    repeat (2) tick();

    // done arriving on the timeout cycle is a normal release
    do_reset();
    req = 4'b0010;
    wait_grant("dt_grant", 4'b0010);
    repeat (63) tick();
    check("dt_still_held", 32'({grant, db_estado}), 32'({4'b0010, 4'd2}));
    pulse_done(4'b0010);
    check("dt_no_err", 32'({grant, timeout_err, db_estado}), 32'({4'b0, 1'b0, 4'd3}));
    req = 4'b0000;
    tick();

    // habilitado gating
    habilitado = 1'b0;
    req = 4'b0011;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      done = (k == 1) ? 4'b0011 : 4'b0000;
      tick();
      check($sformatf("hab_blocked%0d", k), 32'({grant, db_estado}), 32'd0);
    end
    done = 4'b0;
    habilitado = 1'b1;
    wait_grant("hab_grant", 4'b0001);
    habilitado = 1'b0;
    tick();
    pulse_done(4'b0010);
    check("hab_foreign_done", 32'({grant, db_estado}), 32'({4'b0001, 4'd2}));
    pulse_done(4'b0001);
    check("hab_release", 32'({grant, db_estado}), 32'({4'b0, 4'd3}));
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("hab_no_regrant%0d", k), 32'({grant, db_estado}), 32'd0);
    end

    // Reset while a grant is held
    habilitado = 1'b1;
    req = 4'b1111;
    do_reset();
    wait_grant("rst_g0", 4'b0001);
    pulse_done(4'b0001);
    wait_grant("rst_g1", 4'b0010);
    reset = 1'b0;
    tick();
    check("rst_mid_grant",
          32'({grant, grant_id, ocupado, timeout_err, db_estado}), 32'd0);
    reset = 1'b1;
    req = 4'b0110;
    wait_grant("rst_first_after", 4'b0010);
    req = 4'b0000;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
